// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register byte offsets,
// FSM state encoding and CTRL bit positions.
package irq_ctrl_pkg;

  // Byte offsets in the device window; only bits [4:2] are decoded.
  localparam logic [7:0] OFF_CTRL = 8'h00;
  localparam logic [7:0] OFF_MASK = 8'h04;
  localparam logic [7:0] OFF_PEND = 8'h08;
  localparam logic [7:0] OFF_VEC  = 8'h0C;
  localparam logic [7:0] OFF_EDGE = 8'h10;

  localparam int CTRL_GE = 0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_ctrl_prio.sv
// Fixed-priority encoder: lowest set index of eligible wins.
module irq_prio_enc #(
  parameter int N_IRQ = 6
) (
  input  logic [N_IRQ-1:0] eligible,
  output logic             any,
  output logic [2:0]       idx
);

  always_comb begin
    any = 1'b0;
    idx = 3'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        any = 1'b1;
        idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller feeding the CPU CP0 interrupt input.
// Define IRQ_SYNC_EN to put a 2-flop synchronizer on irq_in (adds 2 cycles).
//
//   state     | meaning
//   S_IDLE    | no request outstanding, waiting for an eligible source
//   S_REQ     | int_req high for latched int_vec, waiting for int_ack
//   S_SERVICE | source in service, no new request until EOI
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_IRQ = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             int_req,
  input  logic             int_ack,
  output logic [2:0]       int_vec
);

  state_t             state, state_nxt;
  logic               ge, isr_valid, isr_nxt;
  logic [N_IRQ-1:0]   mask, edge_sel, pend, pend_nxt;
  logic [N_IRQ-1:0]   irq_s, irq_q, prev;
  logic [N_IRQ-1:0]   eligible, vec_oh, w1c, ack_clr, edge_set;
  logic [2:0]         off, vec_nxt, win_idx;
  logic               win_any, eoi;
  logic               unused_bits;

  assign off         = Addr[4:2];
  assign unused_bits = ^{Addr[7:5], Addr[1:0], Din};

`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync1, sync2;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
    end
  end
  assign irq_s = sync2;
`else
  assign irq_s = irq_in;
`endif

  assign eoi      = WE && (off == OFF_VEC[4:2]);
  assign w1c      = (WE && (off == OFF_PEND[4:2])) ? (Din[N_IRQ-1:0] & edge_sel) : '0;
  assign edge_set = irq_q & ~prev;
  assign eligible = ge ? (pend & mask) : '0;
  assign vec_oh   = N_IRQ'(1) << int_vec;

  // A fresh edge beats a same-cycle clear; level bits just follow the sampled line.
  assign pend_nxt = (edge_sel & (edge_set | (pend & ~(w1c | ack_clr)))) |
                    (~edge_sel & irq_q);

  irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio (
    .eligible (eligible),
    .any      (win_any),
    .idx      (win_idx)
  );

  always_comb begin
    state_nxt = state;
    vec_nxt   = int_vec;
    isr_nxt   = isr_valid;
    ack_clr   = '0;
    case (state)
      S_IDLE: begin
        if (win_any) begin
          state_nxt = S_REQ;
          vec_nxt   = win_idx;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          state_nxt = S_SERVICE;
          isr_nxt   = 1'b1;
          ack_clr   = vec_oh & edge_sel;
        end else if (!ge || !(|(eligible & vec_oh))) begin
          state_nxt = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (eoi) begin
          state_nxt = S_IDLE;
          isr_nxt   = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ge        <= 1'b0;
      mask      <= '0;
      edge_sel  <= '0;
      pend      <= '0;
      irq_q     <= '0;
      prev      <= '0;
      int_req   <= 1'b0;
      int_vec   <= 3'd0;
      isr_valid <= 1'b0;
    end else begin
      irq_q     <= irq_s;
      prev      <= irq_q;
      pend      <= pend_nxt;
      state     <= state_nxt;
      int_vec   <= vec_nxt;
      isr_valid <= isr_nxt;
      int_req   <= (state_nxt == S_REQ);
      if (WE && (off == OFF_CTRL[4:2])) ge       <= Din[CTRL_GE];
      if (WE && (off == OFF_MASK[4:2])) mask     <= Din[N_IRQ-1:0];
      if (WE && (off == OFF_EDGE[4:2])) edge_sel <= Din[N_IRQ-1:0];
    end
  end

  always_comb begin
    Dout = 32'd0;
    case (off)
      OFF_CTRL[4:2]: Dout = {31'd0, ge};
      OFF_MASK[4:2]: Dout = 32'(mask);
      OFF_PEND[4:2]: Dout = 32'(pend);
      OFF_VEC[4:2]:  Dout = {isr_valid, 28'd0, int_vec};
      OFF_EDGE[4:2]: Dout = 32'(edge_sel);
      default:       Dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: scenario tasks with a queue of expected vectors.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  Addr = 8'h00;
  logic        WE = 1'b0;
  logic [31:0] Din = 32'd0;
  logic [31:0] Dout;
  logic [5:0]  irq_in = 6'd0;
  logic        int_req;
  logic        int_ack = 1'b0;
  logic [2:0]  int_vec;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] exp_q[$];

  irq_ctrl #(.N_IRQ(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .irq_in  (irq_in),
    .int_req (int_req),
    .int_ack (int_ack),
    .int_vec (int_vec)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = a; Din = d; WE = 1'b1;
    @(negedge clk);
    WE = 1'b0; Din = 32'd0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = Dout;
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    irq_in = 6'h3F;
    repeat (2) @(negedge clk);
    n_tests++;
    if (int_req !== 1'b0) begin n_fail++; $display("FAIL reset_int_req: got %b expected 0", int_req); end
    n_tests++;
    if (int_vec !== 3'd0) begin n_fail++; $display("FAIL reset_int_vec: got %0d expected 0", int_vec); end
    for (int a = 0; a < 8; a++) begin
      bus_read(8'(a * 4), d);
      n_tests++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL reset_dout off=%0h: got %h expected 0", a * 4, d); end
    end
    irq_in = 6'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_edge_basic();
    logic [31:0] d;
    logic [2:0]  e;
    bus_write(8'h00, 32'd1);
    bus_write(8'h04, 32'h01);
    bus_write(8'h10, 32'h01);
    irq_in = 6'h01;
    exp_q.push_back(3'd0);
    @(negedge clk);
    irq_in = 6'h00;
    n_tests++;
    if (int_req !== 1'b0) begin n_fail++; $display("FAIL edge_lat_k: got %b expected 0", int_req); end
    @(negedge clk);
    n_tests++;
    if (int_req !== 1'b0) begin n_fail++; $display("FAIL edge_lat_k1: got %b expected 0", int_req); end
    bus_read(8'h08, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL edge_pend_set: got %h expected 1", d); end
    @(negedge clk);
    n_tests++;
    if (int_req !== 1'b1) begin n_fail++; $display("FAIL edge_lat_k2: got %b expected 1", int_req); end
    e = exp_q.pop_front();
    n_tests++;
    if (int_vec !== e) begin n_fail++; $display("FAIL edge_vec: got %0d expected %0d", int_vec, e); end
    do_ack();
    n_tests++;
    if (int_req !== 1'b0) begin n_fail++; $display("FAIL edge_req_after_ack: got %b expected 0", int_req); end
    bus_read(8'h08, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL edge_pend_ack_clr: got %h expected 0", d); end
    bus_read(8'h0C, d);
    n_tests++;
    if (d !== 32'h80000000) begin n_fail++; $display("FAIL edge_vec_reg: got %h expected 80000000", d); end
    bus_write(8'h0C, 32'd0);
    bus_read(8'h0C, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL edge_eoi: got %h expected 0", d); end
  endtask

  task automatic test_level_prio();
    logic [31:0] d;
    logic [2:0]  e;
    bit ok;
    bus_write(8'h10, 32'h00);
    bus_write(8'h04, 32'h06);
    irq_in = 6'h06;
    exp_q.push_back(3'd1);
    wait_req(6, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL level_req_timeout: got no int_req expected int_req"); end
    e = exp_q.pop_front();
    n_tests++;
    if (int_vec !== e) begin n_fail++; $display("FAIL level_prio_vec: got %0d expected %0d", int_vec, e); end
    bus_read(8'h08, d);
    n_tests++;
    if (d !== 32'h06) begin n_fail++; $display("FAIL level_pend: got %h expected 6", d); end
    do_ack();
    bus_read(8'h0C, d);
    n_tests++;
    if (d !== 32'h80000001) begin n_fail++; $display("FAIL level_vec_reg: got %h expected 80000001", d); end
    bus_write(8'h0C, 32'd0);
    exp_q.push_back(3'd1);
    wait_req(4, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL level_rereq_timeout: got no int_req expected int_req"); end
    e = exp_q.pop_front();
    n_tests++;
    if (int_vec !== e) begin n_fail++; $display("FAIL level_rereq_vec: got %0d expected %0d", int_vec, e); end
    irq_in = 6'h00;
    repeat (3) @(negedge clk);
    n_tests++;
    if (int_req !== 1'b0) begin n_fail++; $display("FAIL level_withdraw: got %b expected 0", int_req); end
    bus_read(8'h0C, d);
    n_tests++;
    if (d !== 32'h00000001) begin n_fail++; $display("FAIL level_withdraw_vec: got %h expected 1", d); end
  endtask

  task automatic test_no_nesting();
    logic [31:0] d;
    logic [2:0]  e;
    bit ok;
    bit seen;
    bus_write(8'h10, 32'h09);
    bus_write(8'h04, 32'h01);
    irq_in = 6'h01;
    exp_q.push_back(3'd0);
    @(negedge clk);
    irq_in = 6'h00;
    wait_req(4, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || int_vec !== e) begin n_fail++; $display("FAIL nest_first_req: got req=%b vec=%0d expected req=1 vec=%0d", ok, int_vec, e); end
    do_ack();
    bus_write(8'h04, 32'h08);
    irq_in = 6'h08;
    exp_q.push_back(3'd3);
    @(negedge clk);
    irq_in = 6'h00;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (int_req) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL nest_req_in_service: got %b expected 0", seen); end
    bus_read(8'h08, d);
    n_tests++;
    if (d !== 32'h08) begin n_fail++; $display("FAIL nest_pend: got %h expected 8", d); end
    bus_write(8'h0C, 32'd0);
    wait_req(4, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL nest_after_eoi_timeout: got no int_req expected int_req"); end
    e = exp_q.pop_front();
    n_tests++;
    if (int_vec !== e) begin n_fail++; $display("FAIL nest_after_eoi_vec: got %0d expected %0d", int_vec, e); end
    do_ack();
    bus_read(8'h08, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL nest_pend_ack_clr: got %h expected 0", d); end
    bus_write(8'h0C, 32'd0);
  endtask

  task automatic test_ge_withdraw();
    logic [31:0] d;
    logic [2:0]  e;
    bit ok;
    bus_write(8'h10, 32'h01);
    bus_write(8'h04, 32'h01);
    irq_in = 6'h01;
    exp_q.push_back(3'd0);
    @(negedge clk);
    irq_in = 6'h00;
    wait_req(4, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || int_vec !== e) begin n_fail++; $display("FAIL ge_first_req: got req=%b vec=%0d expected req=1 vec=%0d", ok, int_vec, e); end
    bus_write(8'h00, 32'd0);
    n_tests++;
    if (int_req !== 1'b1) begin n_fail++; $display("FAIL ge_old_value: got %b expected 1", int_req); end
    @(negedge clk);
    n_tests++;
    if (int_req !== 1'b0) begin n_fail++; $display("FAIL ge_withdraw: got %b expected 0", int_req); end
    bus_read(8'h08, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL ge_pend_kept: got %h expected 1", d); end
    bus_write(8'h00, 32'd1);
    exp_q.push_back(3'd0);
    wait_req(4, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || int_vec !== e) begin n_fail++; $display("FAIL ge_reenable_req: got req=%b vec=%0d expected req=1 vec=%0d", ok, int_vec, e); end
    do_ack();
    bus_write(8'h0C, 32'd0);
  endtask

  task automatic test_w1c_vs_edge();
    logic [31:0] d;
    bus_write(8'h00, 32'd0);
    irq_in = 6'h01;
    @(negedge clk);
    irq_in = 6'h00;
    @(negedge clk);
    bus_read(8'h08, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL w1c_setup_pend: got %h expected 1", d); end
    bus_write(8'h08, 32'h1);
    bus_read(8'h08, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_clear: got %h expected 0", d); end
    @(negedge clk);
    irq_in = 6'h01;
    @(negedge clk);
    irq_in = 6'h00;
    Addr = 8'h08; Din = 32'h1; WE = 1'b1;
    @(negedge clk);
    WE = 1'b0; Din = 32'd0;
    bus_read(8'h08, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL w1c_set_wins: got %h expected 1", d); end
    bus_write(8'h08, 32'h1);
  endtask

  task automatic test_reset_mid_req();
    logic [31:0] d;
    logic [2:0]  e;
    bit ok;
    bus_write(8'h00, 32'd1);
    bus_write(8'h04, 32'h3F);
    irq_in = 6'h01;
    exp_q.push_back(3'd0);
    @(negedge clk);
    irq_in = 6'h00;
    wait_req(4, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || int_vec !== e) begin n_fail++; $display("FAIL rst_setup_req: got req=%b vec=%0d expected req=1 vec=%0d", ok, int_vec, e); end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (int_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got %b expected 0", int_req); end
    for (int a = 0; a < 8; a++) begin
      bus_read(8'(a * 4), d);
      n_tests++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL rst_dout off=%0h: got %h expected 0", a * 4, d); end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_level_prio();
    test_no_nesting();
    test_ge_withdraw();
    test_w1c_vs_edge();
    test_reset_mid_req();
    n_tests++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
